// File: rtl/load_store_engine_pkg.sv
// Shared types and helpers for the byte-fed load/store engine.
package load_store_engine_pkg;

  typedef enum logic [2:0] {
    ActNop         = 3'd0,
    ActPushAddress = 3'd1,
    ActPushData    = 3'd2,
    ActClear       = 3'd3,
    ActAccess      = 3'd4
  } act_e;

  typedef enum logic [1:0] {
    ErrNone        = 2'd0,
    ErrMisaligned  = 2'd1,
    ErrIllegalSize = 2'd2,
    ErrTimeout     = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRequest = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam logic [1:0] SizeByte       = 2'd0;
  localparam logic [1:0] SizeHalfword   = 2'd1;
  localparam logic [1:0] SizeWord       = 2'd2;
  localparam logic [1:0] SizeDoubleword = 2'd3;

  function automatic logic size_legal(input logic [1:0] size, input int unsigned data_width);
    return (32'd1 << size) <= (data_width / 32'd8);
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/load_store_engine_load_extender.sv
// Right-aligned load data narrowed to the access size, then sign- or zero-extended.
module load_extender #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_i,
  output logic [DATA_WIDTH-1:0] ext_o
);

  logic [6:0]            nbits;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [DATA_WIDTH-1:0] top_shifted;
  logic                  fill;

  always_comb begin
    nbits       = 7'd8 << size_i;
    // Shifting by >= DATA_WIDTH yields zero, so full-width accesses keep every bit.
    keep_mask   = ~({DATA_WIDTH{1'b1}} << nbits);
    top_shifted = rdata_i >> (nbits - 7'd1);
    fill        = top_shifted[0] & sign_i;
    ext_o       = (rdata_i & keep_mask) | ({DATA_WIDTH{fill}} & ~keep_mask);
  end

endmodule

// File: rtl/load_store_engine.sv
// Byte-fed load/store front end: assembles address/data, then runs one request/ack access.
module load_store_engine
  import load_store_engine_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [2:0]               act,
  input  logic [7:0]               data,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               error,
  output logic [ADDRESS_WIDTH-1:0] target_address,
  output logic [DATA_WIDTH-1:0]    target_data,
  output logic                     memory_request,
  output logic                     memory_write,
  output logic [1:0]               memory_size,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_write_data,
  input  logic                     memory_acknowledge,
  input  logic [DATA_WIDTH-1:0]    memory_read_data
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                   state_q, state_d;
  err_e                     err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic                     write_q, write_d;
  logic                     sign_q, sign_d;
  logic [1:0]               size_q, size_d;
  logic [CntW-1:0]          count_q, count_d;

  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] load_ext;

  assign op = data[3:0];

  load_extender #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extender (
    .rdata_i(memory_read_data),
    .size_i (size_q),
    .sign_i (sign_q),
    .ext_o  (load_ext)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      err_q   <= ErrNone;
      addr_q  <= '0;
      tdata_q <= '0;
      write_q <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SizeByte;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      tdata_q <= tdata_d;
      write_q <= write_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    addr_d  = addr_q;
    tdata_d = tdata_q;
    write_d = write_q;
    sign_d  = sign_q;
    size_d  = size_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        case (act_e'(act))
          ActPushAddress: addr_d  = (addr_q << 8) | ADDRESS_WIDTH'(data);
          ActPushData:    tdata_d = (tdata_q << 8) | DATA_WIDTH'(data);
          ActClear: begin
            addr_d  = '0;
            tdata_d = '0;
            err_d   = ErrNone;
          end
          ActAccess: begin
            size_d  = op[1:0];
            write_d = op[2];
            sign_d  = op[3] & ~op[2];
            count_d = '0;
            // Size legality is checked before alignment.
            if (!size_legal(op[1:0], DATA_WIDTH)) begin
              err_d   = ErrIllegalSize;
              state_d = StDone;
            end else if ((addr_q[2:0] & align_mask(op[1:0])) != 3'b000) begin
              err_d   = ErrMisaligned;
              state_d = StDone;
            end else begin
              err_d   = ErrNone;
              state_d = StRequest;
            end
          end
          default: ;
        endcase
      end
      StRequest: begin
        // Acknowledge takes priority over a timeout landing in the same cycle.
        if (memory_acknowledge) begin
          if (!write_q) tdata_d = load_ext;
          count_d = '0;
          state_d = StDone;
        end else if (count_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = ErrTimeout;
          count_d = '0;
          state_d = StDone;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy              = (state_q == StRequest);
    done              = (state_q == StDone);
    memory_request    = (state_q == StRequest);
    error             = err_q;
    target_address    = addr_q;
    target_data       = tdata_q;
    memory_write      = memory_request & write_q;
    memory_size       = memory_request ? size_q : SizeByte;
    memory_address    = memory_request ? addr_q : '0;
    memory_write_data = memory_request ? tdata_q : '0;
  end

endmodule

// File: tb/tb_load_store_engine.sv
// Scoreboard bench for load_store_engine (16-bit address, 32-bit data, 4-cycle timeout).
module tb_load_store_engine;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clock;
  logic          reset_n;
  logic [2:0]    act;
  logic [7:0]    data;
  logic          busy;
  logic          done;
  logic [1:0]    error;
  logic [AW-1:0] target_address;
  logic [DW-1:0] target_data;
  logic          memory_request;
  logic          memory_write;
  logic [1:0]    memory_size;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] memory_write_data;
  logic          memory_acknowledge;
  logic [DW-1:0] memory_read_data;

  load_store_engine #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .act               (act),
    .data              (data),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .target_address    (target_address),
    .target_data       (target_data),
    .memory_request    (memory_request),
    .memory_write      (memory_write),
    .memory_size       (memory_size),
    .memory_address    (memory_address),
    .memory_write_data (memory_write_data),
    .memory_acknowledge(memory_acknowledge),
    .memory_read_data  (memory_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
    logic [1:0]    size;
    int            req_cycles;
    int            latency;
    logic [1:0]    err;
    logic [DW-1:0] tdata;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] a, input logic [7:0] d);
    act  = a;
    data = d;
    @(negedge clock);
    act  = 3'd0;
    data = 8'h00;
  endtask

  task automatic push_addr(input logic [7:0] b);
    cmd(3'd1, b);
    m_addr = (m_addr << 8) | AW'(b);
  endtask

  task automatic push_data(input logic [7:0] b);
    cmd(3'd2, b);
    m_data = (m_data << 8) | DW'(b);
  endtask

  task automatic clear();
    cmd(3'd3, 8'h00);
    m_addr = '0;
    m_data = '0;
  endtask

  // ack_at: request cycle (1-based) carrying the acknowledge, 0 = never.
  task automatic access(input string name, input logic [3:0] op, input int ack_at,
                        input logic [DW-1:0] rdata, input logic [1:0] exp_err,
                        input int exp_req, input int exp_lat, input logic [DW-1:0] exp_tdata,
                        input bit poke_addr);
    exp_t e;
    exp_t got;
    int   reqcyc;
    bit   got_done;
    e.addr = m_addr; e.wdata = m_data; e.write = op[2]; e.size = op[1:0];
    e.req_cycles = exp_req; e.latency = exp_lat; e.err = exp_err; e.tdata = exp_tdata;
    exp_q.push_back(e);
    reqcyc   = 0;
    got_done = 0;
    cmd(3'd4, {4'h0, op});
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (memory_request) begin
        reqcyc++;
        if (reqcyc == 1) begin
          check_eq({name, ".addr"},  64'(memory_address),    64'(exp_q[0].addr));
          check_eq({name, ".wdata"}, 64'(memory_write_data), 64'(exp_q[0].wdata));
          check_eq({name, ".write"}, 64'(memory_write),      64'(exp_q[0].write));
          check_eq({name, ".size"},  64'(memory_size),       64'(exp_q[0].size));
        end
        memory_acknowledge = (reqcyc == ack_at);
        memory_read_data   = rdata;
        if (poke_addr && reqcyc == 2) begin
          act  = 3'd1;
          data = 8'h55;
        end else begin
          act  = 3'd0;
          data = 8'h00;
        end
      end else begin
        memory_acknowledge = 1'b0;
        act                = 3'd0;
      end
      if (done) begin
        got_done = 1;
        got = exp_q.pop_front();
        check_eq({name, ".err"},     64'(error),       64'(got.err));
        check_eq({name, ".tdata"},   64'(target_data), 64'(got.tdata));
        check_eq({name, ".reqcyc"},  64'(reqcyc),      64'(got.req_cycles));
        check_eq({name, ".latency"}, 64'(i),           64'(got.latency));
      end
      @(negedge clock);
    end
    act = 3'd0;
    memory_acknowledge = 1'b0;
    if (!got_done) begin
      check_eq({name, ".done_seen"}, 64'(0), 64'(1));
      void'(exp_q.pop_front());
    end
    if (exp_err == 2'd0 && !op[2]) m_data = exp_tdata;
  endtask

  initial begin
    bit saw_done;
    reset_n = 1'b0;
    act = 3'd0;
    data = 8'h00;
    memory_acknowledge = 1'b0;
    memory_read_data = '0;
    m_addr = '0;
    m_data = '0;
    #12;
    check_eq("rst.busy",    64'(busy),           64'(0));
    check_eq("rst.done",    64'(done),           64'(0));
    check_eq("rst.error",   64'(error),          64'(0));
    check_eq("rst.request", 64'(memory_request), 64'(0));
    check_eq("rst.taddr",   64'(target_address), 64'(0));
    check_eq("rst.tdata",   64'(target_data),    64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Acknowledge while idle must be ignored.
    memory_acknowledge = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_eq("idle_ack.busy", 64'(busy | done | memory_request), 64'(0));
    memory_acknowledge = 1'b0;

    push_addr(8'h12);
    push_addr(8'h34);
    check_eq("push.taddr", 64'(target_address), 64'(16'h1234));
    access("hw_load_zx", 4'h1, 1, 32'hDEAD_8001, 2'd0, 1, 1, 32'h0000_8001, 0);
    access("hw_load_sx", 4'h9, 1, 32'hDEAD_8001, 2'd0, 1, 1, 32'hFFFF_8001, 0);

    clear();
    push_addr(8'h01);
    push_addr(8'h00);
    push_data(8'hAA);
    push_data(8'hBB);
    push_data(8'hCC);
    push_data(8'hDD);
    access("w_store", 4'h6, 1, 32'h1111_1111, 2'd0, 1, 1, 32'hAABB_CCDD, 0);
    access("b_load_sx", 4'h8, 2, 32'h1234_56F0, 2'd0, 2, 2, 32'hFFFF_FFF0, 0);

    clear();
    push_addr(8'h01);
    push_addr(8'h02);
    access("misalign", 4'h2, 1, 32'h0, 2'd1, 0, 0, m_data, 0);
    @(negedge clock);
    check_eq("misalign.sticky", 64'(error), 64'(1));
    clear();
    check_eq("clear.error", 64'(error),          64'(0));
    check_eq("clear.taddr", 64'(target_address), 64'(0));

    push_addr(8'h01);
    push_addr(8'h01);
    access("illegal_sz", 4'h3, 1, 32'h0, 2'd2, 0, 0, m_data, 0);

    clear();
    push_addr(8'h00);
    push_addr(8'h40);
    access("timeout", 4'h0, 0, 32'h0, 2'd3, TO, TO, m_data, 1);
    check_eq("timeout.taddr_kept", 64'(target_address), 64'(m_addr));
    access("ack_last", 4'h8, TO, 32'h0000_00A5, 2'd0, TO, TO, 32'hFFFF_FFA5, 0);
    access("ack_last_zx", 4'h0, TO, 32'h0000_01A5, 2'd0, TO, TO, 32'h0000_00A5, 0);

    // Reset in the middle of a request.
    cmd(3'd4, 8'h00);
    check_eq("mid_rst.req_before", 64'(memory_request), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst.req_after", 64'(memory_request), 64'(0));
    check_eq("mid_rst.busy",      64'(busy),           64'(0));
    check_eq("mid_rst.taddr",     64'(target_address), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done) saw_done = 1;
    end
    check_eq("mid_rst.no_done", 64'(saw_done), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_engine.md
Name: load_store_engine

Overview:
- Parametrised successor to the byte-serial load/store front end.
- A controller feeds 8-bit command bytes: address and data registers are assembled by byte shifts, then a single access command launches a load or store.
- The access runs over a request/acknowledge memory port and supports byte, halfword and word sizes, sign/zero extension, alignment checking and an acknowledge timeout.
- Sits between the sequencer's byte datapath and the memory arbiter.

Parameters:
- ADDRESS_WIDTH, 16, width of the memory address. Multiple of 8, at least 8.
- DATA_WIDTH, 32, width of the memory data. 8/16/32/64 only.
- TIMEOUT_CYCLES, 255, request cycles without acknowledge before abort. Must be at least 1.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- act  input  3  command: 0 nop, 1 push address byte, 2 push data byte, 3 clear, 4 access, 5-7 reserved
- data  input  8  command operand
- busy  output  1  access in flight; commands ignored
- done  output  1  one-cycle pulse when an access finishes (success or error)
- error  output  2  0 none, 1 misaligned, 2 illegal size, 3 timeout; sticky
- target_address  output  ADDRESS_WIDTH  assembled address
- target_data  output  DATA_WIDTH  store data / load result
- memory_request  output  1  access request, held until acknowledge or timeout
- memory_write  output  1  1 store, 0 load; valid with request
- memory_size  output  2  log2 bytes; valid with request
- memory_address  output  ADDRESS_WIDTH  equals target_address during request
- memory_write_data  output  DATA_WIDTH  equals target_data during request
- memory_acknowledge  input  1  completes the current request
- memory_read_data  input  DATA_WIDTH  right-aligned load data, valid with acknowledge

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, timeout counter 0.
- State IDLE:
  - act 1: target_address <= {target_address << 8, data}, truncated to ADDRESS_WIDTH.
  - act 2: target_data <= {target_data << 8, data}, truncated to DATA_WIDTH.
  - act 3: target_address, target_data and error <= 0.
  - act 5-7: no effect.
  - act 4 decodes data: op = data[3:0]; size = op[1:0]; write = op[2]; sign = op[3] (loads only). Error is cleared, then:
    - if (1 << size) > DATA_WIDTH/8: error <= 2, done pulses next cycle, no request.
    - else if target_address mod (1 << size) != 0: error <= 1, done pulses next cycle, no request.
    - else: go to REQUEST; memory_request rises the next cycle.
- State REQUEST:
  - busy = 1; memory_request = 1; write/size/address/data held stable; counter increments each cycle.
  - On acknowledge:
    - load: target_data <= memory_read_data low (8 << size) bits, sign- or zero-extended to DATA_WIDTH.
    - store: target_data unchanged.
    - then go to DONE.
  - Acknowledge in the first request cycle is legal, giving minimum latency act 4 -> done = 3 cycles.
  - Counter reaches TIMEOUT_CYCLES with no acknowledge: drop the request, error <= 3, go to DONE.
  - Acknowledge in the same cycle as the timeout: acknowledge wins, no error.
- State DONE: done = 1, busy = 0, request = 0; go to IDLE next cycle. A command presented during DONE is ignored.
- Acknowledge while not requesting: ignored.
- Any act while busy: ignored, no state change.
- Reset mid-request: request drops immediately (asynchronous); no done pulse.

Decomposition:
- Package load_store_engine_pkg holds:
  - act enum: NOP, PUSH_ADDRESS, PUSH_DATA, CLEAR, ACCESS.
  - error enum: NONE, MISALIGNED, ILLEGAL_SIZE, TIMEOUT.
  - state enum: IDLE, REQUEST, DONE.
  - size constants: BYTE = 0, HALFWORD = 1, WORD = 2, DOUBLEWORD = 3.
- One sub-module, load_extender: combinational size/sign extension of read data, parametrised on DATA_WIDTH.

Test Plan:
- Push address bytes 0x12, 0x34 (ADDRESS_WIDTH = 16); act 4 with op = 0x1 (halfword load); acknowledge with memory_read_data = 0xDEAD_8001 -> request at address 0x1234, size 1, write 0; target_data = 0x0000_8001; done pulses 3 cycles after act 4 with immediate acknowledge.
- Same access with op = 0x9 (sign) -> target_data = 0xFFFF_8001.
- Push data bytes 0xAA, 0xBB, 0xCC, 0xDD at address 0x0100; op = 0x6 (word store) -> memory_write_data = 0xAABB_CCDD, write 1, size 2; target_data unchanged after acknowledge.
- Address 0x0102 with op = 0x2 (word load) -> error = 1, no request, done pulse; a following act 3 clears error to 0.
- DATA_WIDTH = 32 with op = 0x3 -> error = 2, no request.
- TIMEOUT_CYCLES = 4, acknowledge never asserted -> request held exactly 4 cycles then drops; error = 3; done pulses. Acknowledge on cycle 4 -> no error. Act 1 during the request leaves target_address unchanged. reset_n low mid-request clears request asynchronously.
